linear_layer_start_fifo: RTL and testbench

Start-token FIFO controller between the Linear_Layer dataflow scheduler and each `PE_i4xi4_pack` process. It wraps an SRL-style shift register with occupancy tracking, ap_fifo-style handshakes, first-word-fall-through output and sticky debug flags. The producer pushes one start token per PE invocation; the PE pops one token per `ap_start` it consumes.

---
 rtl/linear_layer_fifo_pkg.sv | 15 +
 rtl/linear_layer_srl_store.sv | 28 ++
 rtl/linear_layer_start_fifo.sv | 86 ++++++++
 tb/tb_linear_layer_start_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_layer_fifo_pkg.sv
// Shared types and sizing helpers for the Linear_Layer start-token FIFO.
package linear_layer_fifo_pkg;

   localparam int FIFO_DEPTH_DEF = 7;
   localparam int ADDR_WIDTH_DEF = 3;

   typedef logic [ADDR_WIDTH_DEF:0] occ_t;

   function automatic int addr_width_for(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/linear_layer_srl_store.sv
// Shift-on-write token storage with an addressed combinational read port.
module linear_layer_srl_store #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int SLOTS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [SLOTS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[0] <= din;
         for (int i = 1; i < SLOTS; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign dout = mem[addr];

endmodule

// File: rtl/linear_layer_start_fifo.sv
// Start-token FIFO controller: counter, read address, registered flags,
// high-water mark and sticky error flags around the shift-register store.
module linear_layer_start_fifo
   import linear_layer_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = addr_width_for(FIFO_DEPTH_DEF),
   parameter int DEPTH      = FIFO_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_write,
   input  logic                  if_write_ce,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read,
   input  logic                  if_read_ce,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   occupancy,
   output logic [ADDR_WIDTH:0]   high_water,
   output logic                  err_overflow,
   output logic                  err_underflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

   logic                  wr_req;
   logic                  rd_req;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH:0]   count_next;
   logic [ADDR_WIDTH:0]   count_m1;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH-1:0] addr_next;

   assign wr_req = if_write & if_write_ce;
   assign rd_req = if_read & if_read_ce;
   assign push   = wr_req & if_full_n;
   assign pop    = rd_req & if_empty_n;

   always_comb begin
      count_next = occupancy;
      unique case ({push, pop})
         2'b10:   count_next = occupancy + 1'b1;
         2'b01:   count_next = occupancy - 1'b1;
         default: count_next = occupancy;
      endcase
   end

   // Read index tracks the oldest token; parked at 0 when empty.
   assign count_m1  = count_next - 1'b1;
   assign addr_next = (count_next == '0) ? '0 : count_m1[ADDR_WIDTH-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occupancy     <= '0;
         addr          <= '0;
         high_water    <= '0;
         if_full_n     <= 1'b1;
         if_empty_n    <= 1'b0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         occupancy  <= count_next;
         addr       <= addr_next;
         if_full_n  <= (count_next != DEPTH_C);
         if_empty_n <= (count_next != '0);
         if (count_next > high_water) high_water <= count_next;
         if (wr_req & ~if_full_n) err_overflow <= 1'b1;
         if (rd_req & ~if_empty_n) err_underflow <= 1'b1;
      end
   end

   linear_layer_srl_store #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_store (
      .clk (clk),
      .we  (push),
      .addr(addr),
      .din (if_din),
      .dout(if_dout)
   );

endmodule

// File: tb/tb_linear_layer_start_fifo.sv
// Directed self-checking bench for linear_layer_start_fifo (8-bit tokens, depth 7).
module tb_linear_layer_start_fifo;
   import linear_layer_fifo_pkg::*;

   logic       clk;
   logic       reset;
   logic       if_write;
   logic       if_write_ce;
   logic [7:0] if_din;
   logic       if_full_n;
   logic       if_read;
   logic       if_read_ce;
   logic [7:0] if_dout;
   logic       if_empty_n;
   occ_t       occupancy;
   occ_t       high_water;
   logic       err_overflow;
   logic       err_underflow;

   int checks = 0;
   int errors = 0;

   linear_layer_start_fifo #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(3),
      .DEPTH     (7)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .if_write     (if_write),
      .if_write_ce  (if_write_ce),
      .if_din       (if_din),
      .if_full_n    (if_full_n),
      .if_read      (if_read),
      .if_read_ce   (if_read_ce),
      .if_dout      (if_dout),
      .if_empty_n   (if_empty_n),
      .occupancy    (occupancy),
      .high_water   (high_water),
      .err_overflow (err_overflow),
      .err_underflow(err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_write = 1'b0;
      if_read  = 1'b0;
   endtask

   task automatic push_n(input logic [7:0] vals[$]);
      foreach (vals[i]) begin
         if_write = 1'b1;
         if_din   = vals[i];
         tick();
      end
      idle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      if_write = 1'b0; if_write_ce = 1'b1; if_din = 8'h00;
      if_read = 1'b0; if_read_ce = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      checks++;
      if ({if_full_n, if_empty_n} !== 2'b10) begin
         errors++;
         $display("FAIL reset_flags: got %b want 10", {if_full_n, if_empty_n});
      end
      checks++;
      if (occupancy !== 4'd0 || high_water !== 4'd0) begin
         errors++;
         $display("FAIL reset_count: occ %0d hw %0d want 0 0", occupancy, high_water);
      end
      checks++;
      if ({err_overflow, err_underflow} !== 2'b00) begin
         errors++;
         $display("FAIL reset_err: got %b want 00", {err_overflow, err_underflow});
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
      push_n('{8'h11, 8'h22, 8'h33});
      checks++;
      if (occupancy !== 4'd3) begin
         errors++;
         $display("FAIL basic_occ: got %0d want 3", occupancy);
      end
      if_read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (if_empty_n !== 1'b1 || if_dout !== exp[i]) begin
            errors++;
            $display("FAIL basic_pop%0d: dout %h vld %b want %h 1",
                     i, if_dout, if_empty_n, exp[i]);
         end
         tick();
      end
      idle();
      checks++;
      if (if_empty_n !== 1'b0 || high_water !== 4'd3) begin
         errors++;
         $display("FAIL basic_end: empty_n %b hw %0d want 0 3", if_empty_n, high_water);
      end
   endtask

   task automatic test_full();
      push_n('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07});
      checks++;
      if (if_full_n !== 1'b0 || occupancy !== 4'd7) begin
         errors++;
         $display("FAIL full_flag: full_n %b occ %0d want 0 7", if_full_n, occupancy);
      end
      push_n('{8'h08});
      checks++;
      if (err_overflow !== 1'b1 || occupancy !== 4'd7) begin
         errors++;
         $display("FAIL full_ovf: ovf %b occ %0d want 1 7", err_overflow, occupancy);
      end
      if_read = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         checks++;
         if (if_dout !== 8'(i) || if_empty_n !== 1'b1) begin
            errors++;
            $display("FAIL full_pop%0d: dout %h vld %b want %h 1", i, if_dout, if_empty_n, 8'(i));
         end
         tick();
      end
      idle();
      checks++;
      if (if_empty_n !== 1'b0 || high_water !== 4'd7) begin
         errors++;
         $display("FAIL full_drain: empty_n %b hw %0d want 0 7", if_empty_n, high_water);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] q[$];
      logic [7:0] v;
      q = '{8'h31, 8'h32, 8'h33};
      push_n(q);
      for (int k = 0; k < 5; k++) begin
         v = 8'hA0 + 8'(k);
         if_write = 1'b1; if_din = v; if_read = 1'b1;
         checks++;
         if (if_dout !== q[0]) begin
            errors++;
            $display("FAIL b2b_dout%0d: got %h want %h", k, if_dout, q[0]);
         end
         void'(q.pop_front());
         q.push_back(v);
         tick();
         checks++;
         if (occupancy !== 4'd3) begin
            errors++;
            $display("FAIL b2b_occ%0d: got %0d want 3", k, occupancy);
         end
      end
      idle();
      push_n('{8'hB0, 8'hB1, 8'hB2, 8'hB3});
      q.push_back(8'hB0); q.push_back(8'hB1); q.push_back(8'hB2); q.push_back(8'hB3);
      if_write = 1'b1; if_din = 8'hCC; if_read = 1'b1;
      checks++;
      if (if_full_n !== 1'b0 || if_dout !== q[0]) begin
         errors++;
         $display("FAIL b2b_full: full_n %b dout %h want 0 %h", if_full_n, if_dout, q[0]);
      end
      void'(q.pop_front());
      tick();
      idle();
      checks++;
      if (occupancy !== 4'd6 || if_full_n !== 1'b1) begin
         errors++;
         $display("FAIL b2b_fullpop: occ %0d full_n %b want 6 1", occupancy, if_full_n);
      end
      if_read = 1'b1;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (if_dout !== q[0]) begin
            errors++;
            $display("FAIL b2b_drain%0d: got %h want %h", k, if_dout, q[0]);
         end
         void'(q.pop_front());
         tick();
      end
      idle();
      checks++;
      if (if_empty_n !== 1'b0 || occupancy !== 4'd0) begin
         errors++;
         $display("FAIL b2b_empty: empty_n %b occ %0d want 0 0", if_empty_n, occupancy);
      end
   endtask

   task automatic test_empty_simul();
      checks++;
      if (err_underflow !== 1'b0) begin
         errors++;
         $display("FAIL unf_pre: got %b want 0", err_underflow);
      end
      if_write = 1'b1; if_din = 8'h5C; if_read = 1'b1;
      tick();
      idle();
      checks++;
      if (err_underflow !== 1'b1 || occupancy !== 4'd1) begin
         errors++;
         $display("FAIL unf_set: unf %b occ %0d want 1 1", err_underflow, occupancy);
      end
      checks++;
      if (if_dout !== 8'h5C || if_empty_n !== 1'b1) begin
         errors++;
         $display("FAIL unf_dout: dout %h vld %b want 5c 1", if_dout, if_empty_n);
      end
      if_read = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_async_reset();
      push_n('{8'h41, 8'h42, 8'h43, 8'h44});
      checks++;
      if (occupancy !== 4'd4) begin
         errors++;
         $display("FAIL arst_pre: occ %0d want 4", occupancy);
      end
      #3 reset = 1'b1;
      #1;
      checks++;
      if (occupancy !== 4'd0 || high_water !== 4'd0 ||
          {if_full_n, if_empty_n} !== 2'b10) begin
         errors++;
         $display("FAIL arst_now: occ %0d hw %0d flags %b want 0 0 10",
                  occupancy, high_water, {if_full_n, if_empty_n});
      end
      checks++;
      if ({err_overflow, err_underflow} !== 2'b00) begin
         errors++;
         $display("FAIL arst_err: got %b want 00", {err_overflow, err_underflow});
      end
      #2 reset = 1'b0;
      if_write = 1'b1; if_din = 8'h99;
      tick();
      idle();
      checks++;
      if (if_dout !== 8'h99 || occupancy !== 4'd1 || if_empty_n !== 1'b1) begin
         errors++;
         $display("FAIL arst_push: dout %h occ %0d vld %b want 99 1 1",
                  if_dout, occupancy, if_empty_n);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_back_to_back();
      test_empty_simul();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
